// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared types, timing defaults and width helpers for the panel input conditioner
package panel_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam int unsigned CLK_HZ              = 25_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;     // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 12_500_000;  // 0.5 s
    localparam int unsigned DEF_REPEAT_RATE     = 2_500_000;   // 0.1 s

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_count; never less than one bit.
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debouncer and edge-strobe generator
module debounce_channel
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CW       = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          synced;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise_q;
    logic          rise_d;
    logic          fall_q;
    logic          fall_d;

    // Flops idle at the inactive pin level so the corrected value starts at 0.
    assign synced = sync2_q ^ INVERT;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
                rise_d   = ~stable_q;
                fall_d   = stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= INVERT;
            sync2_q  <= INVERT;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// rtl/panel_input_conditioner.sv - front-panel button/sense conditioning with per-button auto-repeat
module panel_input_conditioner
    import panel_pkg::*;
#(
    parameter int unsigned         N_BTN           = 6,
    parameter int unsigned         SENSE_W         = 8,
    parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned         REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned         REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter logic [N_BTN-1:0]    BTN_INVERT      = '0,
    parameter logic [SENSE_W-1:0]  SENSE_INVERT    = '0,
    parameter logic [N_BTN-1:0]    REPEAT_MASK     = N_BTN'(6'b101000)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_raw,
    input  logic [SENSE_W-1:0] sense_raw,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [SENSE_W-1:0] sense_level,
    output logic               sense_change
);

    localparam int unsigned RW = count_width(max_u(REPEAT_DELAY, REPEAT_RATE));

    logic [N_BTN-1:0]   btn_rise;
    logic [N_BTN-1:0]   btn_fall;
    logic [SENSE_W-1:0] sense_rise;
    logic [SENSE_W-1:0] sense_fall;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (BTN_INVERT[g])
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (btn_raw[g]),
            .level_o (btn_level[g]),
            .rise_o  (btn_rise[g]),
            .fall_o  (btn_fall[g])
        );
    end

    for (genvar g = 0; g < SENSE_W; g++) begin : g_sense
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (SENSE_INVERT[g])
        ) u_deb (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (sense_raw[g]),
            .level_o (sense_level[g]),
            .rise_o  (sense_rise[g]),
            .fall_o  (sense_fall[g])
        );
    end

    assign btn_release  = btn_fall;
    assign sense_change = |(sense_rise | sense_fall);

    for (genvar g = 0; g < N_BTN; g++) begin : g_rpt
        if (REPEAT_MASK[g]) begin : g_on
            rpt_state_e    state_q;
            rpt_state_e    state_d;
            logic [RW-1:0] cnt_q;
            logic [RW-1:0] cnt_d;
            logic          tick;

            // Counter counts down to zero; a release takes priority over a coinciding tick.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                tick    = 1'b0;
                unique case (state_q)
                    RPT_IDLE: begin
                        if (btn_rise[g]) begin
                            state_d = RPT_DELAY;
                            cnt_d   = RW'(REPEAT_DELAY - 1);
                        end
                    end
                    RPT_DELAY, RPT_REPEAT: begin
                        if (btn_fall[g]) begin
                            state_d = RPT_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == '0) begin
                            tick    = 1'b1;
                            state_d = RPT_REPEAT;
                            cnt_d   = RW'(REPEAT_RATE - 1);
                        end else begin
                            cnt_d = cnt_q - RW'(1);
                        end
                    end
                    default: begin
                        state_d = RPT_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= RPT_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign btn_press[g] = btn_rise[g] | tick;
        end else begin : g_off
            assign btn_press[g] = btn_rise[g];
        end
    end

endmodule

// File: tb/tb_panel_input_conditioner.sv
// tb/tb_panel_input_conditioner.sv - randomized and directed bench against a behavioural model
module tb_panel_input_conditioner;

    localparam int          DEB   = 4;
    localparam int          RD    = 20;
    localparam int          RR    = 5;
    localparam logic [5:0]  BINV  = 6'h00;
    localparam logic [7:0]  SINV  = 8'h0F;
    localparam logic [5:0]  RMASK = 6'b100000;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn_raw;
    logic [7:0] sense_raw;
    logic [5:0] btn_level, btn_press, btn_release;
    logic [7:0] sense_level;
    logic       sense_change;

    panel_input_conditioner #(
        .N_BTN(6), .SENSE_W(8), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .BTN_INVERT(BINV), .SENSE_INVERT(SINV), .REPEAT_MASK(RMASK)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sense_raw(sense_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .sense_level(sense_level), .sense_change(sense_change)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Model: pin seen two edges late, level flips after DEB consecutive differing samples,
    // repeats follow press time arithmetically.
    logic [5:0] m_bd1, m_bd2, m_blvl, m_press, m_rel;
    logic [7:0] m_sd1, m_sd2, m_slvl;
    logic       m_change;
    int         b_run[6];
    int         s_run[8];
    int         rise_at[6];
    int         cyc;

    task automatic model_reset();
        m_bd1 = '0; m_bd2 = '0; m_blvl = '0; m_press = '0; m_rel = '0;
        m_sd1 = '0; m_sd2 = '0; m_slvl = '0; m_change = 1'b0;
        for (int i = 0; i < 6; i++) begin b_run[i] = 0; rise_at[i] = 0; end
        for (int i = 0; i < 8; i++) s_run[i] = 0;
        cyc = 0;
    endtask

    task automatic model_step();
        logic [5:0] bs;
        logic [7:0] ss;
        logic [5:0] rose;
        int k;
        cyc++;
        bs = m_bd2; m_bd2 = m_bd1; m_bd1 = btn_raw ^ BINV;
        ss = m_sd2; m_sd2 = m_sd1; m_sd1 = sense_raw ^ SINV;
        m_press = '0; m_rel = '0; m_change = 1'b0; rose = '0;
        for (int i = 0; i < 6; i++) begin
            if (bs[i] != m_blvl[i]) begin
                b_run[i]++;
                if (b_run[i] == DEB) begin
                    b_run[i] = 0;
                    m_blvl[i] = ~m_blvl[i];
                    if (m_blvl[i]) begin rose[i] = 1'b1; rise_at[i] = cyc; end
                    else m_rel[i] = 1'b1;
                end
            end else b_run[i] = 0;
        end
        for (int i = 0; i < 6; i++) begin
            if (rose[i]) m_press[i] = 1'b1;
            else if (RMASK[i] && m_blvl[i]) begin
                k = cyc - rise_at[i];
                if (k >= RD && ((k - RD) % RR) == 0) m_press[i] = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (ss[i] != m_slvl[i]) begin
                s_run[i]++;
                if (s_run[i] == DEB) begin
                    s_run[i] = 0;
                    m_slvl[i] = ~m_slvl[i];
                    m_change = 1'b1;
                end
            end else s_run[i] = 0;
        end
    endtask

    task automatic compare_all();
        check_eq("btn_level", btn_level, m_blvl);
        check_eq("btn_press", btn_press, m_press);
        check_eq("btn_release", btn_release, m_rel);
        check_eq("sense_level", sense_level, m_slvl);
        check_eq("sense_change", sense_change, m_change);
        check_eq("press_rel_excl", btn_press & btn_release, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_level"}, btn_level, 0);
        check_eq({tag, "_press"}, btn_press, 0);
        check_eq({tag, "_release"}, btn_release, 0);
        check_eq({tag, "_sense"}, sense_level, 0);
        check_eq({tag, "_change"}, sense_change, 0);
    endtask

    // Asserted between edges so the outputs must clear without a clock.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk);
        check_all_zero({tag, "_hold"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    int n_press, n_rel, n_chg, p;

    initial begin
        reset = 1'b1;
        btn_raw = 6'h3F;
        sense_raw = 8'h00;
        model_reset();
        @(negedge clk);
        check_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;

        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 5) check_eq("rst_lvl5", btn_level, 6'h00);
        end
        check_eq("rst_lvl6", btn_level, 6'h3F);
        check_eq("rst_press6", btn_press, 6'h3F);
        step();
        check_eq("rst_press7", btn_press, 6'h00);

        btn_raw = 6'h00;
        for (int c = 0; c < 12; c++) step();

        n_press = 0;
        btn_raw = 6'h01;
        for (int c = 0; c < 3; c++) begin step(); n_press += btn_press[0]; end
        btn_raw = 6'h00;
        for (int c = 0; c < 12; c++) begin step(); n_press += btn_press[0] | btn_level[0]; end
        check_eq("glitch_btn0", n_press, 0);

        n_press = 0; n_rel = 0;
        btn_raw = 6'h02;
        for (int c = 1; c <= 40; c++) begin
            step();
            n_press += btn_press[1];
            if (c == 6) check_eq("btn1_press_t6", btn_press[1], 1'b1);
        end
        btn_raw = 6'h00;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_rel += btn_release[1];
            if (c == 6) check_eq("btn1_rel_t6", btn_release[1], 1'b1);
        end
        check_eq("btn1_npress", n_press, 1);
        check_eq("btn1_nrel", n_rel, 1);

        n_press = 0;
        btn_raw = 6'h20;
        for (int c = 1; c <= 60; c++) begin
            step();
            n_press += btn_press[5];
            if (c == 26 || c == 31) check_eq("btn5_repeat", btn_press[5], 1'b1);
        end
        btn_raw = 6'h00;
        for (int c = 1; c <= 20; c++) begin
            step();
            n_press += btn_press[5];
            if (c == 6) check_eq("btn5_rel_nopress", {btn_release[5], btn_press[5]}, 2'b10);
        end
        check_eq("btn5_npress", n_press, 9);

        n_chg = 0;
        sense_raw = 8'hA5;
        for (int c = 1; c <= 20; c++) begin
            step();
            n_chg += sense_change;
            if (c == 5) check_eq("sense_t5", sense_level, 8'h0F);
            if (c == 6) check_eq("sense_t6", sense_level, 8'hAA);
        end
        check_eq("sense_nchg", n_chg, 1);

        btn_raw = 6'h20;
        for (int c = 0; c < 35; c++) step();
        async_reset("midrpt");
        n_press = 0;
        for (int c = 1; c <= 5; c++) begin step(); n_press += btn_press[5]; end
        check_eq("midrpt_quiet", n_press, 0);
        step();
        check_eq("midrpt_fresh", btn_press[5], 1'b1);

        for (int seg = 0; seg < 12; seg++) begin
            case ($urandom_range(0, 2))
                0: p = 3;
                1: p = 10;
                default: p = 60;
            endcase
            for (int c = 0; c < 200; c++) begin
                for (int i = 0; i < 6; i++)
                    if ($urandom_range(0, p - 1) == 0) btn_raw[i] = ~btn_raw[i];
                for (int i = 0; i < 8; i++)
                    if ($urandom_range(0, p - 1) == 0) sense_raw[i] = ~sense_raw[i];
                if (seg == 7 && c == 100) async_reset("rnd_rst");
                else step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_input_conditioner.md
Name: panel_input_conditioner

Overview:
Parametrised front-panel input block that replaces the ad-hoc raw button and switch wiring between the board top and the machine core. Per channel, it:
- synchronises N pushbuttons and a SENSE_W-bit sense/data switch bank,
- debounces them,
- generates one-cycle press/release strobes,
- adds configurable auto-repeat on selected buttons (e.g. examine-next, deposit-next, step).

It sits between the board pins (btn, sw, gp/gn sense inputs) and the core's step/examine/deposit and sense inputs.

Parameters:
- N_BTN, 6, number of pushbutton channels
- SENSE_W, 8, width of the switch/sense bank
- DEBOUNCE_CYCLES, 250000, clean-level cycles required before a stable change (10 ms @ 25 MHz); must be >= 1
- REPEAT_DELAY, 12500000, cycles from press strobe to first auto-repeat strobe (0.5 s); must be >= 1
- REPEAT_RATE, 2500000, cycles between subsequent repeat strobes (0.1 s); must be >= 1
- BTN_INVERT, {N_BTN{1'b0}}, per-button mask; a 1 means the raw pin is active-low
- SENSE_INVERT, {SENSE_W{1'b0}}, per-bit inversion mask for the sense bank
- REPEAT_MASK, 6'b101000, per-button auto-repeat enable

Ports:
- clk, input, 1, system clock (25 MHz)
- reset, input, 1, asynchronous, active-high; clears all state
- btn_raw, input, N_BTN, raw button pins, asynchronous to clk
- sense_raw, input, SENSE_W, raw switch/sense pins, asynchronous
- btn_level, output, N_BTN, debounced active-high button state
- btn_press, output, N_BTN, one-cycle strobe on debounced press or auto-repeat
- btn_release, output, N_BTN, one-cycle strobe on debounced release
- sense_level, output, SENSE_W, debounced, polarity-corrected sense bank
- sense_change, output, 1, one-cycle strobe when any sense_level bit changes

Behaviour:
- Reset (async, active-high):
  - all outputs 0;
  - synchroniser flops load the inactive level (BTN_INVERT / SENSE_INVERT bit values);
  - counters 0; repeat FSMs to IDLE.
- Reset asserted mid-count or mid-repeat aborts immediately. No strobe is emitted on reset deassertion, even if a button is held: a held button must be seen pressed for DEBOUNCE_CYCLES after reset before btn_press fires.
- Synchroniser: 2 flops per bit. Polarity XOR is applied after the second flop.
- Debounce, per bit:
  - counter width $clog2(DEBOUNCE_CYCLES+1);
  - if synced value == stable value, counter clears;
  - else counter increments; on reaching DEBOUNCE_CYCLES-1 while still mismatched, the stable value toggles and the counter clears;
  - any return to the stable value before that point clears the counter (glitch rejected).
- Latency: a clean edge at the pin changes the stable level DEBOUNCE_CYCLES+2 cycles later.
- Strobes:
  - btn_press[i] asserts in the first cycle btn_level[i] reads 1.
  - btn_release[i] asserts in the first cycle btn_level[i] reads 0.
  - sense_change asserts in the first cycle sense_level differs from its previous value; several bits changing in the same cycle give a single strobe.
- Repeat FSM, per channel with REPEAT_MASK[i]=1; one shared-width counter per channel, $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE: on debounced rise, emit press strobe, load counter, go to DELAY.
  - DELAY: count REPEAT_DELAY cycles. On terminal count, emit press strobe, reload, go to REPEAT.
  - REPEAT: emit a press strobe every REPEAT_RATE cycles while held.
  - From DELAY or REPEAT, debounced fall returns to IDLE. The release strobe fires; no press strobe that cycle, even if the terminal count coincides.
- Timing: the first repeat strobe comes exactly REPEAT_DELAY cycles after the initial strobe, then every REPEAT_RATE cycles.
- Channels with REPEAT_MASK[i]=0 never leave IDLE; they get exactly one press strobe per debounced press.
- btn_press and btn_release are never high together on one channel.
- Channels are fully independent; simultaneous events on different channels all produce strobes in the same cycle.

Decomposition:
- Shared package panel_pkg holds:
  - repeat FSM state enum (IDLE, DELAY, REPEAT);
  - default timing constants for a 25 MHz clock;
  - a clog2-based width helper.
- Sub-module debounce_channel (sync + debounce + edge strobes, 1 bit, parametrised on DEBOUNCE_CYCLES and invert). It is instantiated N_BTN+SENSE_W times via generate.
- The repeat FSM stays in the top block, per channel.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, BTN_INVERT=0, REPEAT_MASK=6'b100000):
- Reset: reset high, btn_raw=6'h3F -> all outputs 0. After release, btn_level=6'h3F at cycle 6 with btn_press=6'h3F for exactly one cycle.
- Glitch rejection: btn_raw[0] high for 3 cycles, then low -> btn_level[0] and btn_press[0] stay 0 throughout.
- Clean press/release on btn[1], held 40 cycles:
  - press strobe 6 cycles after the rising edge, single;
  - no repeats;
  - release strobe 6 cycles after the falling edge.
- Auto-repeat on btn[5], held 60 cycles:
  - press strobes at t, t+20, t+25, t+30 … while held;
  - release leads to IDLE with no press strobe in the release cycle.
- Sense bank: sense_raw 8'h00 -> 8'hA5 with SENSE_INVERT=8'h0F -> sense_level=8'hAA after 6 cycles; sense_change pulses exactly once.
- Async reset mid-repeat: assert reset in REPEAT state -> all outputs 0 in the same cycle; no strobes until a fresh debounced press.
